// File: rtl/axis_bram_pkg.sv
// Shared types and sizing helpers for the AXI-Stream <-> wide BRAM row packer.
package axis_bram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_FILL,
    WR_COMMIT,
    RD_ISSUE,
    RD_WAIT,
    RD_DRAIN,
    DONE
  } state_e;

  function automatic int cnt_width(input int words_per_row);
    return $clog2(words_per_row);
  endfunction

  function automatic int row_width(input int word_width, input int words_per_row);
    return word_width * words_per_row;
  endfunction

endpackage

// File: rtl/axis_bram_row_buffer.sv
// One BRAM row held as word slots: word-indexed write, clear, full-row load, word-indexed read.
module axis_bram_row_buffer
  import axis_bram_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int WORDS_PER_ROW = 36,
  localparam int CNT_W        = cnt_width(WORDS_PER_ROW),
  localparam int ROW_W        = row_width(WORD_WIDTH, WORDS_PER_ROW)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic                  ld_en,
  input  logic [ROW_W-1:0]      ld_row,
  input  logic [CNT_W-1:0]      rd_idx,
  output logic [WORD_WIDTH-1:0] rd_word,
  output logic [ROW_W-1:0]      row_nxt
);

  logic [WORD_WIDTH-1:0] slot_q [WORDS_PER_ROW];
  logic [WORD_WIDTH-1:0] slot_d [WORDS_PER_ROW];

  // clear wins over load, load wins over a single-word write
  always_comb begin
    for (int i = 0; i < WORDS_PER_ROW; i++) begin
      if (clr)
        slot_d[i] = '0;
      else if (ld_en)
        slot_d[i] = ld_row[i*WORD_WIDTH +: WORD_WIDTH];
      else if (wr_en && (wr_idx == CNT_W'(i)))
        slot_d[i] = wr_word;
      else
        slot_d[i] = slot_q[i];
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  // next-row view lets the committer capture a row in the same cycle its last word lands
  always_comb begin
    row_nxt = '0;
    for (int i = 0; i < WORDS_PER_ROW; i++)
      row_nxt[i*WORD_WIDTH +: WORD_WIDTH] = slot_d[i];
  end

  assign rd_word = slot_q[rd_idx];

endmodule

// File: rtl/axis_bram_row_packer.sv
// Packs stream words into wide BRAM rows (write mode) and unpacks rows into a stream (read mode).
module axis_bram_row_packer
  import axis_bram_pkg::*;
#(
  parameter int WORD_WIDTH      = 16,
  parameter int WORDS_PER_ROW   = 36,
  parameter int ADDR_WIDTH      = 12,
  parameter int BRAM_RD_LATENCY = 2,
  localparam int CNT_W          = cnt_width(WORDS_PER_ROW),
  localparam int ROW_W          = row_width(WORD_WIDTH, WORDS_PER_ROW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_index,
  input  logic [ADDR_WIDTH-1:0] bound_index,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [WORD_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [ROW_W-1:0]      bram_wdata,
  input  logic [ROW_W-1:0]      bram_rdata
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS_PER_ROW - 1);
  localparam logic [7:0]       LAT_LAST  = 8'(BRAM_RD_LATENCY - 1);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt, bound, bound_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [7:0]            lat_cnt, lat_nxt;
  logic                  last_seen, last_nxt;
  logic                  s_hs, m_hs, at_bound, last_slot;
  logic                  buf_clr, buf_ld;
  logic [WORD_WIDTH-1:0] rd_word;
  logic [ROW_W-1:0]      row_nxt;

  assign at_bound  = (addr == bound);
  assign last_slot = (count == LAST_SLOT);

  assign s_axis_tready = (state == WR_FILL);
  assign m_axis_tvalid = (state == RD_DRAIN);
  assign m_axis_tdata  = m_axis_tvalid ? rd_word : '0;
  assign m_axis_tlast  = m_axis_tvalid && last_slot && at_bound;

  assign s_hs    = s_axis_tready && s_axis_tvalid;
  assign m_hs    = m_axis_tvalid && m_axis_tready;
  assign buf_clr = (state == IDLE) || (state == WR_COMMIT);
  assign buf_ld  = (state == RD_WAIT) && (lat_cnt == LAT_LAST);

  axis_bram_row_buffer #(
    .WORD_WIDTH   (WORD_WIDTH),
    .WORDS_PER_ROW(WORDS_PER_ROW)
  ) u_row_buffer (
    .clk    (clk),
    .clr    (buf_clr),
    .wr_en  (s_hs),
    .wr_idx (count),
    .wr_word(s_axis_tdata),
    .ld_en  (buf_ld),
    .ld_row (bram_rdata),
    .rd_idx (count),
    .rd_word(rd_word),
    .row_nxt(row_nxt)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    bound_nxt = bound;
    count_nxt = count;
    lat_nxt   = lat_cnt;
    last_nxt  = last_seen;
    case (state)
      IDLE: if (start) begin
        addr_nxt  = start_index;
        bound_nxt = bound_index;
        count_nxt = '0;
        last_nxt  = 1'b0;
        state_nxt = mode ? WR_FILL : RD_ISSUE;
      end
      WR_FILL: if (s_hs) begin
        if (last_slot || s_axis_tlast) begin
          last_nxt  = s_axis_tlast;
          state_nxt = WR_COMMIT;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      WR_COMMIT: begin
        count_nxt = '0;
        if (at_bound || last_seen) begin
          state_nxt = DONE;
        end else begin
          addr_nxt  = addr + ADDR_WIDTH'(1);
          state_nxt = WR_FILL;
        end
      end
      RD_ISSUE: begin
        lat_nxt   = '0;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          count_nxt = '0;
          state_nxt = RD_DRAIN;
        end else begin
          lat_nxt = lat_cnt + 8'd1;
        end
      end
      RD_DRAIN: if (m_hs) begin
        if (!last_slot) begin
          count_nxt = count + CNT_W'(1);
        end else if (at_bound) begin
          state_nxt = DONE;
        end else begin
          addr_nxt  = addr + ADDR_WIDTH'(1);
          state_nxt = RD_ISSUE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are registered from the next state so strobes line up with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      bound      <= '0;
      count      <= '0;
      lat_cnt    <= '0;
      last_seen  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      bound     <= bound_nxt;
      count     <= count_nxt;
      lat_cnt   <= lat_nxt;
      last_seen <= last_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      bram_en   <= (state_nxt == WR_COMMIT) || (state_nxt == RD_ISSUE);
      bram_we   <= (state_nxt == WR_COMMIT);
      if ((state_nxt == WR_COMMIT) || (state_nxt == RD_ISSUE))
        bram_addr <= addr_nxt;
      if (state_nxt == WR_COMMIT)
        bram_wdata <= row_nxt;
    end
  end

endmodule

// File: tb/tb_axis_bram_row_packer.sv
// Bench for axis_bram_row_packer: BRAM model, stream drivers, row-level reference model.
module tb_axis_bram_row_packer;

  localparam int WW  = 16;
  localparam int WPR = 36;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int RW  = WW * WPR;

  logic clk, rst, mode, start;
  logic [AW-1:0] start_index, bound_index;
  logic busy, done;
  logic [WW-1:0] s_tdata;
  logic s_tvalid, s_tready, s_tlast;
  logic [WW-1:0] m_tdata;
  logic m_tvalid, m_tready, m_tlast;
  logic bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [RW-1:0] bram_wdata, bram_rdata;

  logic pl_en;
  logic [AW-1:0] pl_addr;
  logic [RW-1:0] pl_data;
  logic [RW-1:0] mem [16];
  logic [RW-1:0] rd_p [LAT];

  logic [AW-1:0] wq_addr[$];
  logic [AW-1:0] en_addr[$];
  logic [RW-1:0] wq_data[$];
  logic [WW-1:0] rq_data[$];
  logic          rq_last[$];
  int en_cnt;
  int done_cnt;

  logic [RW-1:0] ref_mem [16];
  logic [WW-1:0] wr_words [128];
  logic [AW-1:0] ew_addr[$];
  logic [RW-1:0] ew_data[$];
  logic [WW-1:0] er_data[$];
  logic          er_last[$];
  int checks;
  int errors;

  axis_bram_row_packer #(
    .WORD_WIDTH(WW), .WORDS_PER_ROW(WPR), .ADDR_WIDTH(AW), .BRAM_RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start),
    .start_index(start_index), .bound_index(bound_index),
    .busy(busy), .done(done),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  // simple-port BRAM: read data valid LAT cycles after the enable cycle
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
    if (bram_en && !bram_we) rd_p[0] <= mem[bram_addr];
    for (int k = 1; k < LAT; k++) rd_p[k] <= rd_p[k-1];
  end
  assign bram_rdata = rd_p[LAT-1];

  always @(negedge clk) begin
    if (bram_en) begin en_cnt++; en_addr.push_back(bram_addr); end
    if (bram_en && bram_we) begin wq_addr.push_back(bram_addr); wq_data.push_back(bram_wdata); end
    if (m_tvalid && m_tready) begin rq_data.push_back(m_tdata); rq_last.push_back(m_tlast); end
    if (done) done_cnt++;
  end

  // rows are consecutive WPR-word chunks; a row closes early on tlast; stop at bound row or tlast
  task automatic model_write(input logic [AW-1:0] sa, ba, input int n, tl, output int acc);
    logic [AW-1:0] a;
    logic [RW-1:0] row;
    bit last;
    int idx;
    ew_addr.delete(); ew_data.delete();
    a = sa; idx = 0;
    while (1) begin
      row = '0; last = 0;
      for (int k = 0; k < WPR && idx < n; k++) begin
        row[k*WW +: WW] = wr_words[idx];
        last = (idx == tl);
        idx++;
        if (last) break;
      end
      ew_addr.push_back(a); ew_data.push_back(row); ref_mem[a] = row;
      if (a == ba || last || idx >= n) break;
      a = a + 4'd1;
    end
    acc = idx;
  endtask

  task automatic model_read(input logic [AW-1:0] sa, ba);
    logic [AW-1:0] a;
    er_data.delete(); er_last.delete();
    a = sa;
    while (1) begin
      for (int k = 0; k < WPR; k++) begin
        er_data.push_back(ref_mem[a][k*WW +: WW]);
        er_last.push_back(a == ba && k == WPR - 1);
      end
      if (a == ba) break;
      a = a + 4'd1;
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [RW-1:0] d);
    @(posedge clk); #1;
    pl_en = 1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 0;
    ref_mem[a] = d;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int k = 0; k < WPR; k++) r[k*WW +: WW] = WW'($urandom);
    return r;
  endfunction

  task automatic run_write(input logic [AW-1:0] sa, ba, input int n, tl, pct, output int acc, output bit seen);
    int i;
    i = 0; seen = 0;
    @(posedge clk); #1;
    mode = 1; start_index = sa; bound_index = ba; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (i < n) begin
        s_tvalid = ($urandom_range(99) < pct);
        s_tdata = wr_words[i];
        s_tlast = (i == tl);
      end else begin
        s_tvalid = 0; s_tlast = 0;
      end
      @(negedge clk);
      if (s_tvalid && s_tready) i++;
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    s_tvalid = 0; s_tlast = 0;
    acc = i;
  endtask

  task automatic run_read(input logic [AW-1:0] sa, ba, input int pct, input bit inject, output bit seen);
    logic [WW-1:0] hd;
    logic hl;
    bit held;
    held = 0; seen = 0; hd = '0; hl = 0;
    @(posedge clk); #1;
    mode = 0; start_index = sa; bound_index = ba; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      m_tready = ($urandom_range(99) < pct);
      start = inject && (c == 45);
      if (start) begin mode = 1; start_index = '0; bound_index = '0; end
      @(negedge clk);
      if (held) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== hd || m_tlast !== hl) begin
          errors++;
          $display("FAIL stall_hold: valid %b data %h last %b, expected valid 1 data %h last %b",
                   m_tvalid, m_tdata, m_tlast, hd, hl);
        end
      end
      held = m_tvalid && !m_tready; hd = m_tdata; hl = m_tlast;
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    m_tready = 0; start = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, s_tready, m_tvalid, m_tlast, bram_en, bram_we} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 0000000", {busy, done, s_tready, m_tvalid, m_tlast, bram_en, bram_we});
    end
    checks++;
    if (bram_addr !== '0 || m_tdata !== '0) begin
      errors++; $display("FAIL reset_addr_tdata: addr %h tdata %h expected 0 0", bram_addr, m_tdata);
    end
    checks++;
    if (bram_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bram_wdata); end
    @(posedge clk); #1; rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, s_tready, m_tvalid, bram_en} !== 5'b0) begin
      errors++; $display("FAIL idle_ctl: got %b expected 00000", {busy, done, s_tready, m_tvalid, bram_en});
    end
  endtask

  task automatic test_basic_write();
    int ea, acc, wb, db;
    bit seen;
    for (int i = 0; i < 72; i++) wr_words[i] = WW'(i);
    model_write(4'd5, 4'd6, 72, 71, ea);
    wb = wq_addr.size(); db = done_cnt;
    run_write(4'd5, 4'd6, 72, 71, 70, acc, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_done_timeout: done seen %0d expected 1", seen); end
    checks++;
    if (wq_addr.size() - wb != ew_addr.size()) begin
      errors++; $display("FAIL basic_nwrites: got %0d expected %0d", wq_addr.size() - wb, ew_addr.size());
    end
    for (int k = 0; k < ew_addr.size() && wb + k < wq_addr.size(); k++) begin
      checks++;
      if (wq_addr[wb+k] !== ew_addr[k] || wq_data[wb+k] !== ew_data[k]) begin
        errors++; $display("FAIL basic_row%0d: addr %0d data %h, expected addr %0d data %h", k, wq_addr[wb+k], wq_data[wb+k], ew_addr[k], ew_data[k]);
      end
    end
    checks++;
    if (acc != ea) begin errors++; $display("FAIL basic_accepted: got %0d expected %0d", acc, ea); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt - db != 1) begin
      errors++; $display("FAIL basic_done_busy: busy %b pulses %0d expected busy 0 pulses 1", busy, done_cnt - db);
    end
  endtask

  task automatic test_early_tlast();
    int ea, acc, wb;
    bit seen, bad;
    for (int i = 0; i < 20; i++) wr_words[i] = WW'($urandom);
    model_write(4'd8, 4'd9, 20, 9, ea);
    wb = wq_addr.size();
    run_write(4'd8, 4'd9, 20, 9, 80, acc, seen);
    checks++;
    if (!seen || wq_addr.size() - wb != 1) begin
      errors++; $display("FAIL early_nwrites: done %0d writes %0d expected done 1 writes 1", seen, wq_addr.size() - wb);
    end
    checks++;
    if (wq_addr.size() > wb && (wq_addr[wb] !== ew_addr[0] || wq_data[wb] !== ew_data[0])) begin
      errors++; $display("FAIL early_row: addr %0d data %h, expected addr %0d data %h", wq_addr[wb], wq_data[wb], ew_addr[0], ew_data[0]);
    end
    checks++;
    if (acc != 10) begin errors++; $display("FAIL early_accepted: got %0d expected 10", acc); end
    s_tvalid = 1; s_tdata = 16'hdead; bad = 0;
    repeat (4) begin @(negedge clk); if (s_tready !== 1'b0) bad = 1; end
    s_tvalid = 0;
    checks++;
    if (bad) begin errors++; $display("FAIL early_tready_after: got 1 expected 0"); end
  endtask

  task automatic test_read_backpressure();
    int rb;
    bit seen;
    preload(4'd3, rand_row());
    preload(4'd4, rand_row());
    model_read(4'd3, 4'd4);
    rb = rq_data.size();
    run_read(4'd3, 4'd4, 50, 0, seen);
    checks++;
    if (!seen || rq_data.size() - rb != er_data.size()) begin
      errors++; $display("FAIL rd_count: done %0d words %0d expected done 1 words %0d", seen, rq_data.size() - rb, er_data.size());
    end
    for (int k = 0; k < er_data.size() && rb + k < rq_data.size(); k++) begin
      checks++;
      if (rq_data[rb+k] !== er_data[k] || rq_last[rb+k] !== er_last[k]) begin
        errors++; $display("FAIL rd_word%0d: data %h last %b expected data %h last %b", k, rq_data[rb+k], rq_last[rb+k], er_data[k], er_last[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int ea, acc, wb, rb;
    bit seen;
    for (int i = 0; i < 80; i++) wr_words[i] = WW'($urandom);
    model_write(4'd15, 4'd0, 80, -1, ea);
    wb = wq_addr.size();
    run_write(4'd15, 4'd0, 80, -1, 90, acc, seen);
    checks++;
    if (!seen || wq_addr.size() - wb != 2) begin
      errors++; $display("FAIL wrap_nwrites: done %0d writes %0d expected done 1 writes 2", seen, wq_addr.size() - wb);
    end
    for (int k = 0; k < 2 && wb + k < wq_addr.size(); k++) begin
      checks++;
      if (wq_addr[wb+k] !== ew_addr[k] || wq_data[wb+k] !== ew_data[k]) begin
        errors++; $display("FAIL wrap_row%0d: addr %0d data %h, expected addr %0d data %h", k, wq_addr[wb+k], wq_data[wb+k], ew_addr[k], ew_data[k]);
      end
    end
    checks++;
    if (acc != ea) begin errors++; $display("FAIL wrap_accepted: got %0d expected %0d", acc, ea); end
    model_read(4'd15, 4'd0);
    rb = rq_data.size();
    run_read(4'd15, 4'd0, 70, 0, seen);
    checks++;
    if (!seen || rq_data.size() - rb != er_data.size()) begin
      errors++; $display("FAIL wrap_rd_count: done %0d words %0d expected done 1 words %0d", seen, rq_data.size() - rb, er_data.size());
    end
    for (int k = 0; k < er_data.size() && rb + k < rq_data.size(); k++) begin
      checks++;
      if (rq_data[rb+k] !== er_data[k] || rq_last[rb+k] !== er_last[k]) begin
        errors++; $display("FAIL wrap_rd_word%0d: data %h last %b expected data %h last %b", k, rq_data[rb+k], rq_last[rb+k], er_data[k], er_last[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ea, acc, wb, e0;
    bit seen, bad;
    @(posedge clk); #1;
    mode = 1; start_index = 4'd1; bound_index = 4'd3; start = 1;
    @(posedge clk); #1;
    start = 0; s_tvalid = 1;
    for (int i = 0; i < 10; i++) begin s_tdata = WW'($urandom); @(posedge clk); #1; end
    e0 = en_cnt; wb = wq_addr.size();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({busy, done, s_tready, m_tvalid, m_tlast, bram_en, bram_we} !== 7'b0) begin
      errors++; $display("FAIL rstmid_ctl: got %b expected 0000000", {busy, done, s_tready, m_tvalid, m_tlast, bram_en, bram_we});
    end
    checks++;
    if (bram_addr !== '0 || bram_wdata !== '0 || m_tdata !== '0) begin
      errors++; $display("FAIL rstmid_data: addr %h tdata %h wdata %h expected all 0", bram_addr, m_tdata, bram_wdata);
    end
    bad = 0;
    repeat (20) begin @(negedge clk); if (s_tready !== 1'b0) bad = 1; end
    s_tvalid = 0;
    checks++;
    if (bad || en_cnt != e0) begin
      errors++; $display("FAIL rstmid_quiet: tready_seen %0d bram_en %0d expected 0 0", bad, en_cnt - e0);
    end
    for (int i = 0; i < 36; i++) wr_words[i] = WW'($urandom);
    model_write(4'd2, 4'd2, 36, 35, ea);
    wb = wq_addr.size();
    run_write(4'd2, 4'd2, 36, 35, 100, acc, seen);
    checks++;
    if (!seen || wq_addr.size() - wb != 1 || acc != ea) begin
      errors++; $display("FAIL rstmid_restart: done %0d writes %0d accepted %0d expected 1 1 %0d", seen, wq_addr.size() - wb, acc, ea);
    end
    checks++;
    if (wq_addr.size() > wb && (wq_addr[wb] !== ew_addr[0] || wq_data[wb] !== ew_data[0])) begin
      errors++; $display("FAIL rstmid_row: addr %0d data %h, expected addr %0d data %h", wq_addr[wb], wq_data[wb], ew_addr[0], ew_data[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int rb, eb, wb;
    bit seen, bad;
    preload(4'd7, rand_row());
    preload(4'd8, rand_row());
    model_read(4'd7, 4'd8);
    rb = rq_data.size(); eb = en_addr.size(); wb = wq_addr.size();
    run_read(4'd7, 4'd8, 100, 1, seen);
    checks++;
    if (!seen || rq_data.size() - rb != er_data.size()) begin
      errors++; $display("FAIL swb_count: done %0d words %0d expected done 1 words %0d", seen, rq_data.size() - rb, er_data.size());
    end
    for (int k = 0; k < er_data.size() && rb + k < rq_data.size(); k++) begin
      checks++;
      if (rq_data[rb+k] !== er_data[k] || rq_last[rb+k] !== er_last[k]) begin
        errors++; $display("FAIL swb_word%0d: data %h last %b expected data %h last %b", k, rq_data[rb+k], rq_last[rb+k], er_data[k], er_last[k]);
      end
    end
    checks++;
    if (en_addr.size() - eb != 2 || wq_addr.size() != wb ||
        (en_addr.size() - eb == 2 && (en_addr[eb] !== 4'd7 || en_addr[eb+1] !== 4'd8))) begin
      errors++; $display("FAIL swb_accesses: count %0d writes %0d expected reads at 7,8 only", en_addr.size() - eb, wq_addr.size() - wb);
    end
    bad = 0;
    repeat (4) begin @(negedge clk); if (busy !== 1'b0) bad = 1; end
    checks++;
    if (bad) begin errors++; $display("FAIL swb_idle_after: busy 1 expected 0"); end
  endtask

  initial begin
    clk = 0; rst = 1; mode = 0; start = 0; start_index = '0; bound_index = '0;
    s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    checks = 0; errors = 0;
    test_reset();
    test_basic_write();
    test_early_tlast();
    test_read_backpressure();
    test_wrap();
    test_reset_mid();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
